// File: rtl/wave_gen_pkg.sv
// Shared mode encoding for the waveform generator slice.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW_UP = 2'd1,
    MODE_SAW_DN = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_t;

endpackage

// File: rtl/wave_prescaler.sv
// Cycle prescaler: counts 0..tick_div inclusive and pulses tick on the last count.
module wave_prescaler #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] tick_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic             w_last;

  // >= rather than == so a count can never run past a shortened limit.
  assign w_last = (r_count >= tick_div);
  assign tick   = en && !rst && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      if (w_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_gen.sv
// Multi-mode waveform generator: triangle, saw up/down and square with
// mode/divisor/duty shadowed so changes land only on period boundaries.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int OUT_W = 6,
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] fnc,
  output logic             tick,
  output logic             period_start
);

  localparam int PH_W = OUT_W + 1;
  localparam logic [PH_W-1:0] MAX_P    = PH_W'((1 << OUT_W) - 1);
  localparam logic [PH_W-1:0] TRI_TOP  = PH_W'(2 * ((1 << OUT_W) - 1));
  localparam logic [PH_W-1:0] TRI_LAST = PH_W'(2 * ((1 << OUT_W) - 1) - 1);

  mode_t            r_mode_s;
  logic [DIV_W-1:0] r_div_s;
  logic [OUT_W-1:0] r_duty_s;
  logic [PH_W-1:0]  r_phase;
  logic [OUT_W-1:0] r_fnc;

  logic [DIV_W-1:0] w_tick_div;
  logic             w_tick;
  logic [PH_W-1:0]  w_last;
  logic             w_wrap;
  logic [PH_W-1:0]  w_phase_nxt;
  logic [OUT_W-1:0] w_fnc_nxt;

  // Triangle runs twice as many phase steps per period, so its ticks come twice as fast.
  assign w_tick_div = (r_mode_s == MODE_TRI) ? (r_div_s >> (OUT_W + 1))
                                             : (r_div_s >> OUT_W);

  wave_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick_div (w_tick_div),
    .tick     (w_tick)
  );

  assign w_last      = (r_mode_s == MODE_TRI) ? TRI_LAST : MAX_P;
  assign w_wrap      = (r_phase >= w_last);
  assign w_phase_nxt = w_wrap ? '0 : r_phase + 1'b1;

  always_comb begin
    w_fnc_nxt = '0;
    case (r_mode_s)
      MODE_TRI: begin
        if (w_phase_nxt <= MAX_P) begin
          w_fnc_nxt = w_phase_nxt[OUT_W-1:0];
        end else begin
          w_fnc_nxt = OUT_W'(TRI_TOP - w_phase_nxt);
        end
      end
      MODE_SAW_UP: w_fnc_nxt = w_phase_nxt[OUT_W-1:0];
      MODE_SAW_DN: w_fnc_nxt = ~w_phase_nxt[OUT_W-1:0];
      MODE_SQUARE: w_fnc_nxt = ({1'b0, r_duty_s} > w_phase_nxt) ? '1 : '0;
      default:     w_fnc_nxt = '0;
    endcase
  end

  assign tick         = w_tick;
  assign period_start = w_tick && w_wrap;
  assign fnc          = r_fnc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= '0;
      r_fnc    <= '0;
      r_mode_s <= mode_t'(mode);
      r_div_s  <= div;
      r_duty_s <= duty;
    end else begin
      if (w_tick) begin
        r_phase <= w_phase_nxt;
        r_fnc   <= w_fnc_nxt;
      end
      // The wrap edge still shapes with the old settings; new ones apply from phase 0 on.
      if (period_start) begin
        r_mode_s <= mode_t'(mode);
        r_div_s  <= div;
        r_duty_s <= duty;
      end
    end
  end

endmodule
